// File: rtl/regfile_pkg.sv
// Shared definitions for the parametrised multi-port register file.
// Optional write-through forwarding is enabled by defining REGFILE_BYPASS_EN.
package regfile_pkg;

  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_ADDR_W = 5;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } rf_state_e;

  // LSB position of port k inside a packed bus of w-bit lanes.
  function automatic int unsigned port_lsb(input int unsigned k, input int unsigned w);
    return k * w;
  endfunction

endpackage

// File: rtl/regfile_rd_port.sv
// One combinational read port: array mux, zero-register gating, ready gating.
// With REGFILE_BYPASS_EN defined, a same-cycle write to the read address is forwarded.
module regfile_rd_port
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned ADDR_W   = DEF_ADDR_W,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic              ready,
  input  logic [ADDR_W-1:0] ra,
  input  logic [DATA_W-1:0] mem [2**ADDR_W],
  output logic [DATA_W-1:0] rd
`ifdef REGFILE_BYPASS_EN
  ,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd
`endif
);

  logic zero_sel;

  assign zero_sel = (ZERO_REG != 0) && (ra == '0);

`ifdef REGFILE_BYPASS_EN
  logic fwd_hit;

  // Writes to the hardwired zero register never forward.
  assign fwd_hit = we && ready && (wa == ra) && !((ZERO_REG != 0) && (wa == '0));
`endif

  always_comb begin
    rd = '0;
    if (!ready || zero_sel) begin
      rd = '0;
    end
`ifdef REGFILE_BYPASS_EN
    else if (fwd_hit) begin
      rd = wd;
    end
`endif
    else begin
      rd = mem[ra];
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-read, single-write register file with post-reset clear sweep and optional zero register.
// Define REGFILE_BYPASS_EN for same-cycle write-through forwarding on the read ports.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned ADDR_W   = DEF_ADDR_W,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        wa,
  input  logic [DATA_W-1:0]        wd,
  input  logic [NUM_RD*ADDR_W-1:0] ra,
  output logic [NUM_RD*DATA_W-1:0] rd,
  output logic                     ready,
  output logic                     wr_drop
);

  localparam int unsigned DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  rf_state_e         state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              ready_q, ready_d;
  logic              wr_drop_q, wr_drop_d;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_wa;
  logic [DATA_W-1:0] mem_wd;
  logic              zero_hit;

  assign zero_hit = (ZERO_REG != 0) && (wa == '0);

  // The sweep and user writes share the single array write port.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    ready_d   = ready_q;
    wr_drop_d = 1'b0;
    mem_we    = 1'b0;
    mem_wa    = wa;
    mem_wd    = wd;
    case (state_q)
      CLEAR: begin
        mem_we    = 1'b1;
        mem_wa    = idx_q;
        mem_wd    = '0;
        idx_d     = idx_q + 1'b1;
        wr_drop_d = we;
        if (idx_q == '1) begin
          state_d = RUN;
          ready_d = 1'b1;
        end
      end
      RUN: begin
        mem_we    = we && !zero_hit;
        wr_drop_d = we && zero_hit;
      end
      default: begin
        state_d = CLEAR;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q   <= CLEAR;
      idx_q     <= '0;
      ready_q   <= 1'b0;
      wr_drop_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      ready_q   <= ready_d;
      wr_drop_q <= wr_drop_d;
    end
  end

  // No per-entry reset so the array stays RAM-inferable.
  always_ff @(posedge clock) begin
    if (reset_n && mem_we) begin
      mem[mem_wa] <= mem_wd;
    end
  end

  assign ready   = ready_q;
  assign wr_drop = wr_drop_q;

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    regfile_rd_port #(
      .DATA_W  (DATA_W),
      .ADDR_W  (ADDR_W),
      .ZERO_REG(ZERO_REG)
    ) u_rd_port (
      .ready(ready_q),
      .ra   (ra[port_lsb(k, ADDR_W) +: ADDR_W]),
      .mem  (mem),
      .rd   (rd[port_lsb(k, DATA_W) +: DATA_W])
`ifdef REGFILE_BYPASS_EN
      ,
      .we   (we),
      .wa   (wa),
      .wd   (wd)
`endif
    );
  end

endmodule
